// File: rtl/if_stage_if.sv
// Bus between the fetch stage, its instruction memory and decode.
// The master side is the fetch stage: it drives the fetch address and the
// IF/ID contents, and it receives the memory word, decode's ready signal
// and the redirect/flush controls.
interface if_stage_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush;

    modport master (
        output imem_pc,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output out_fault,
        input  redirect_valid,
        input  redirect_target,
        input  flush
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  out_fault,
        output redirect_valid,
        output redirect_target,
        output flush
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational
// instruction memory and captures the word into the IF/ID register, which
// decode drains over a valid/ready handshake.
// Optional build macro IF_DELAY_SLOT_EN: when defined, the word fetched in
// the redirect cycle (the delay slot) is kept; otherwise it is squashed and
// a single bubble is inserted.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.master   bus
);

    // Stage 0: PC register. Stage 1: IF/ID register.
    logic [31:0] pc_p0;
    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc_plus4_p1;
    logic        fault_p1;

    logic        advance;
    logic        take_redirect;
    logic        misaligned;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_instr;

    // 32-bit wrapping increment; 32'hFFFF_FFFC rolls over to zero.
    function automatic logic [31:0] incr_pc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // Stage 0 decode: handshake, redirect qualification and fetch word.
    always_comb begin
        advance       = !vld_p1 || bus.out_ready;
        // A redirect is only meaningful while the branch is leaving IF/ID.
        take_redirect = bus.redirect_valid && vld_p1 && bus.out_ready;
        misaligned    = (pc_p0[1:0] != 2'b00);
        pc_plus4      = incr_pc(pc_p0);
        fetch_instr   = misaligned ? 32'h0 : bus.imem_instr;
    end

    // PC and IF/ID update, priority rst > flush > redirect > stall > fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            vld_p1      <= 1'b0;
            instr_p1    <= 32'h0;
            pc_p1       <= 32'h0;
            pc_plus4_p1 <= 32'h0;
            fault_p1    <= 1'b0;
        end else if (bus.flush) begin
            // IF/ID data fields are left as-is; only the valid bit matters.
            pc_p0  <= EXC_VECTOR;
            vld_p1 <= 1'b0;
        end else if (take_redirect) begin
            pc_p0 <= bus.redirect_target;
`ifdef IF_DELAY_SLOT_EN
            // Delay slot: keep the word fetched alongside the branch.
            vld_p1      <= 1'b1;
            instr_p1    <= fetch_instr;
            pc_p1       <= pc_p0;
            pc_plus4_p1 <= pc_plus4;
            fault_p1    <= misaligned;
`else
            // No delay slot: squash the sequential word, one bubble.
            vld_p1 <= 1'b0;
`endif
        end else if (advance) begin
            pc_p0       <= pc_plus4;
            vld_p1      <= 1'b1;
            instr_p1    <= fetch_instr;
            pc_p1       <= pc_p0;
            pc_plus4_p1 <= pc_plus4;
            fault_p1    <= misaligned;
        end
    end

    // Drive the bus from the PC and the IF/ID register.
    always_comb begin
        bus.imem_pc      = pc_p0;
        bus.out_valid    = vld_p1;
        bus.out_instr    = instr_p1;
        bus.out_pc       = pc_p1;
        bus.out_pc_plus4 = pc_plus4_p1;
        bus.out_fault    = fault_p1;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, free-running fetch, stall,
// redirect (with or without IF_DELAY_SLOT_EN), misaligned target, flush,
// reset during stall and PC wrap-around.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0180)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a simple address-derived pattern.
    function automatic logic [31:0] mem(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_instr = mem(bus.imem_pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.flush           = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h want 0", bus.out_pc); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
        n_checks++; if (bus.out_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc_plus4 got %h want 0", bus.out_pc_plus4); end
        n_checks++; if (bus.out_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b want 0", bus.out_fault); end
        n_checks++; if (bus.imem_pc !== 32'h0) begin n_fail++; $display("FAIL reset_imem_pc got %h want 0", bus.imem_pc); end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_in [4];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_in = '{32'hDEAD_BEEF, 32'hDEAD_BEEB, 32'hDEAD_BEE7, 32'hDEAD_BEE3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d] got %0b want 1", i, bus.out_valid); end
            n_checks++; if (bus.out_pc !== exp_pc[i]) begin n_fail++; $display("FAIL fetch_pc[%0d] got %h want %h", i, bus.out_pc, exp_pc[i]); end
            n_checks++; if (bus.out_instr !== exp_in[i]) begin n_fail++; $display("FAIL fetch_instr[%0d] got %h want %h", i, bus.out_instr, exp_in[i]); end
            n_checks++; if (bus.out_pc_plus4 !== exp_pc[i] + 32'd4) begin n_fail++; $display("FAIL fetch_plus4[%0d] got %h want %h", i, bus.out_pc_plus4, exp_pc[i] + 32'd4); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.out_pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 8", i, bus.out_pc); end
            n_checks++; if (bus.out_instr !== 32'hDEAD_BEE7) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want deadbee7", i, bus.out_instr); end
            n_checks++; if (bus.imem_pc !== 32'hC) begin n_fail++; $display("FAIL stall_imem_pc[%0d] got %h want c", i, bus.imem_pc); end
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %0b want 1", i, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        step();
        n_checks++; if (bus.out_pc !== 32'hC) begin n_fail++; $display("FAIL stall_release_pc got %h want c", bus.out_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (bus.out_pc !== 32'h10) begin n_fail++; $display("FAIL branch_pc got %h want 10", bus.out_pc); end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
`ifdef IF_DELAY_SLOT_EN
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL slot_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.out_pc !== 32'h14) begin n_fail++; $display("FAIL slot_pc got %h want 14", bus.out_pc); end
`else
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got %0b want 0", bus.out_valid); end
`endif
        n_checks++; if (bus.imem_pc !== 32'h40) begin n_fail++; $display("FAIL redirect_imem_pc got %h want 40", bus.imem_pc); end
        step();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL target_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.out_pc !== 32'h40) begin n_fail++; $display("FAIL target_pc got %h want 40", bus.out_pc); end
        n_checks++; if (bus.out_instr !== 32'hDEAD_BEAF) begin n_fail++; $display("FAIL target_instr got %h want deadbeaf", bus.out_instr); end
    endtask

    task automatic test_ignored_redirect();
        // Right after reset out_valid is 0, so a redirect must be ignored.
        do_reset();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h80;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ignore_redirect got pc %h vld %0b want 0/1", bus.out_pc, bus.out_valid); end
        n_checks++; if (bus.imem_pc !== 32'h4) begin n_fail++; $display("FAIL ignore_redirect_imem_pc got %h want 4", bus.imem_pc); end
    endtask

    task automatic test_misaligned();
        do_reset();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h42;
        step();
        bus.redirect_valid = 1'b0;
`ifndef IF_DELAY_SLOT_EN
        step();
`else
        step();
        step();
`endif
        // Under the delay-slot build the extra step drains the slot entry.
`ifdef IF_DELAY_SLOT_EN
        n_checks++; if (bus.out_pc !== 32'h46) begin n_fail++; $display("FAIL mis_next_pc got %h want 46", bus.out_pc); end
`else
        n_checks++; if (bus.out_pc !== 32'h42) begin n_fail++; $display("FAIL mis_pc got %h want 42", bus.out_pc); end
        n_checks++; if (bus.out_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault got %0b want 1", bus.out_fault); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL mis_instr got %h want 0", bus.out_instr); end
        n_checks++; if (bus.out_pc_plus4 !== 32'h46) begin n_fail++; $display("FAIL mis_plus4 got %h want 46", bus.out_pc_plus4); end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        step();
        bus.flush           = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.imem_pc !== 32'h180) begin n_fail++; $display("FAIL flush_imem_pc got %h want 180", bus.imem_pc); end
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h180) begin n_fail++; $display("FAIL flush_vector got pc %h vld %0b want 180/1", bus.out_pc, bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'hDEAD_BF6F) begin n_fail++; $display("FAIL flush_instr got %h want deadbf6f", bus.out_instr); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int i = 0; i < 9; i++) step();
        bus.out_ready = 1'b0;
        step();
        n_checks++; if (bus.out_pc !== 32'h20) begin n_fail++; $display("FAIL pre_rst_pc got %h want 20", bus.out_pc); end
        rst = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        step();
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.imem_pc !== 32'h0) begin n_fail++; $display("FAIL rst_stall_imem_pc got %h want 0", bus.imem_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        step();
        n_checks++; if (bus.out_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h want fffffffc", bus.out_pc); end
        n_checks++; if (bus.out_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got %h want 0", bus.out_pc_plus4); end
        step();
        n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc got %h want 0", bus.out_pc); end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.flush           = 1'b0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_ignored_redirect();
        test_misaligned();
        test_flush();
        test_reset_mid_stall();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
